// File: rtl/maquina_bebidas_param.sv
// maquina_bebidas_param: coin-operated beverage dispenser (credit, water/pour/sugar phases, change).
// Optional refund-on-cancel behaviour is enabled by defining CANCEL_REFUND_EN.
module maquina_bebidas_param #(
    parameter int N_PROD     = 4,
    parameter int CRED_W     = 8,
    parameter int MAX_CREDIT = 11,
    parameter int TICK_DIV   = 50_000_000,
    parameter int T_WATER    = 3,
    parameter int T_POUR     = 2,
    parameter int T_SUGAR    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coin100,
    input  logic                     coin500,
    input  logic [N_PROD-1:0]        sel,
    input  logic                     sugar_req,
    input  logic                     cancel,
    input  logic [N_PROD*CRED_W-1:0] price_i,
    output logic                     agua,
    output logic [N_PROD-1:0]        pour,
    output logic                     azucar,
    output logic                     busy,
    output logic                     bebida_lista,
    output logic                     coin_reject,
    output logic [CRED_W-1:0]        change_o,
    output logic                     change_valid,
    output logic [CRED_W-1:0]        display_o
);
    localparam int KW    = $clog2(N_PROD);
    localparam int PW    = $clog2(TICK_DIV + 1);
    localparam int T_MAX = T_WATER > T_POUR ? (T_WATER > T_SUGAR ? T_WATER : T_SUGAR)
                                            : (T_POUR > T_SUGAR ? T_POUR : T_SUGAR);
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {IDLE, CREDIT, WATER, POUR, SUGAR, CHANGE, DONE} state_t;

    state_t            state, state_d;
    logic [CRED_W-1:0] credit, credit_d, change, change_d, cr1, price_k, display_d;
    logic [KW-1:0]     k, k_d, sel_k;
    logic              sug, sug_d, refund, refund_d, rej_d;
    logic [PW-1:0]     pre, pre_d;
    logic [TW-1:0]     ticks, ticks_d;
    logic [CRED_W:0]   sum;
    logic [2:0]        add;
    logic              idle_cr, coin, coin_ok, go, tick, phase_end, cancel_now;
    int                t_len;

`ifdef CANCEL_REFUND_EN
    assign cancel_now = state == CREDIT && cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_now    = 1'b0;
`endif

    always_comb begin
        sel_k = '0;
        for (int i = N_PROD - 1; i >= 0; i--)
            if (sel[i]) sel_k = KW'(i);
    end

    assign price_k   = price_i[sel_k*CRED_W +: CRED_W];
    assign idle_cr   = state == IDLE || state == CREDIT;
    assign coin      = coin100 || coin500;
    assign add       = (coin100 ? 3'd1 : 3'd0) + (coin500 ? 3'd5 : 3'd0);
    assign sum       = {1'b0, credit} + (CRED_W+1)'(add);
    // A coin batch that would overflow MAX_CREDIT is rejected as a whole
    assign coin_ok   = idle_cr && coin && !cancel_now && sum <= (CRED_W+1)'(MAX_CREDIT);
    assign rej_d     = coin && !coin_ok;
    assign cr1       = coin_ok ? sum[CRED_W-1:0] : credit;
    assign go        = (state == CREDIT || coin_ok) && |sel && cr1 >= price_k && !cancel_now;
    assign tick      = pre == PW'(TICK_DIV - 1);
    assign t_len     = state == WATER ? T_WATER : state == POUR ? T_POUR : T_SUGAR;
    assign phase_end = tick && ticks == TW'(t_len - 1);

    always_comb begin
        state_d  = state;
        credit_d = cr1;
        change_d = change;
        k_d      = k;
        sug_d    = sug;
        refund_d = refund;
        pre_d    = tick ? '0 : pre + 1'b1;
        ticks_d  = tick ? ticks + 1'b1 : ticks;
        case (state)
            IDLE, CREDIT: begin
                pre_d   = '0;
                ticks_d = '0;
                if (cancel_now) begin
                    state_d  = CHANGE;
                    change_d = credit;
                    refund_d = 1'b1;
                end else if (go) begin
                    state_d  = WATER;
                    k_d      = sel_k;
                    sug_d    = sugar_req;
                    change_d = cr1 - price_k;
                end else if (coin_ok) state_d = CREDIT;
            end
            WATER, POUR, SUGAR: if (phase_end) begin
                state_d = state == WATER ? POUR : (state == POUR && sug) ? SUGAR : CHANGE;
                pre_d   = '0;
                ticks_d = '0;
            end
            CHANGE: begin
                state_d  = refund ? IDLE : DONE;
                credit_d = '0;
                refund_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        display_d = (state_d == IDLE || state_d == CREDIT) ? credit_d : change_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            credit      <= '0;
            change      <= '0;
            k           <= '0;
            sug         <= 1'b0;
            refund      <= 1'b0;
            pre         <= '0;
            ticks       <= '0;
            coin_reject <= 1'b0;
            display_o   <= '0;
        end else begin
            state       <= state_d;
            credit      <= credit_d;
            change      <= change_d;
            k           <= k_d;
            sug         <= sug_d;
            refund      <= refund_d;
            pre         <= pre_d;
            ticks       <= ticks_d;
            coin_reject <= rej_d;
            display_o   <= display_d;
        end
    end

    assign agua         = state == WATER;
    assign pour         = state == POUR ? N_PROD'(1) << k : '0;
    assign azucar       = state == SUGAR;
    assign busy         = !idle_cr;
    assign bebida_lista = state == DONE;
    assign change_valid = state == CHANGE;
    assign change_o     = change_valid ? change : '0;
endmodule
